// File: rtl/fsm_seq_detector.sv
// fsm_seq_detector: serial PATTERN detector (MSB first) with Mealy/Moore match and saturating count.
// Optional idle-timeout abandonment is built only when SEQDET_TIMEOUT_EN is defined.
module fsm_seq_detector #(
  parameter int unsigned PAT_LEN     = 4,
  parameter logic [31:0] PATTERN     = 4'b1011,
  parameter bit          OVERLAP     = 1'b1,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din_valid,
  input  logic             din,
  output logic             match,
  output logic             match_q,
  output logic             busy,
  output logic [CNT_W-1:0] match_count,
  output logic             timeout
);

  localparam int unsigned PW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned NS_W = 2 * PAT_LEN * PW;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PARTIAL = 1'b1
  } state_e;

  if ((PAT_LEN < 2) || (PAT_LEN > 16)) begin : g_len_chk
    $error("fsm_seq_detector: PAT_LEN must be within 2..16");
  end
  if ((PATTERN >> PAT_LEN) != '0) begin : g_pat_chk
    $error("fsm_seq_detector: PATTERN is wider than PAT_LEN");
  end
  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("fsm_seq_detector: TIMEOUT_CYC must be >= 1");
  end

  // Pattern bit i in arrival order (i = 0 arrives first).
  function automatic logic pat_bit(input int unsigned i);
    logic [31:0] sh;
    sh = PATTERN >> (PAT_LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest proper pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic int unsigned border(input int unsigned k, input logic b);
    int unsigned best;
    logic        ok;
    logic        s;
    best = 0;
    for (int unsigned l = 1; l <= k; l++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < l; m++) begin
        s = ((k + 1 - l + m) == k) ? b : pat_bit(k + 1 - l + m);
        if (s != pat_bit(m)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  function automatic int unsigned next_prog(input int unsigned k, input logic b);
    int unsigned nxt;
    if (b == pat_bit(k)) begin
      if (k < PAT_LEN - 1) nxt = k + 1;
      else                 nxt = OVERLAP ? border(k, b) : 0;
    end else begin
      nxt = border(k, b);
    end
    return nxt;
  endfunction

  function automatic logic [NS_W-1:0] build_ns();
    logic [NS_W-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < PAT_LEN; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        t[(2*k + b)*PW +: PW] = PW'(next_prog(k, b[0]));
      end
    end
    return t;
  endfunction

  // Slot (2*prog + din) holds the next progress value for that state/input pair.
  localparam logic [NS_W-1:0] NS_TAB   = build_ns();
  localparam logic [PW-1:0]   LAST     = PW'(PAT_LEN - 1);
  localparam logic            LAST_BIT = pat_bit(PAT_LEN - 1);

  logic [PW-1:0]    prog_q, prog_d, ns_sel;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;

  assign match       = din_valid && !clear && (prog_q == LAST) && (din == LAST_BIT);
  assign busy        = (state_q == ST_PARTIAL);
  assign match_count = cnt_q;

  always_comb begin
    ns_sel = prog_q;
    for (int unsigned k = 0; k < PAT_LEN; k++) begin
      if (prog_q == PW'(k)) begin
        ns_sel = din ? NS_TAB[(2*k + 1)*PW +: PW] : NS_TAB[(2*k)*PW +: PW];
      end
    end
  end

  always_comb begin
    prog_d = prog_q;
    cnt_d  = cnt_q;
    if (clear) begin
      prog_d = '0;
      cnt_d  = '0;
    end else begin
      if (din_valid)    prog_d = ns_sel;
      else if (tmo_hit) prog_d = '0;
      if (match && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
    state_d = (prog_d != '0) ? ST_PARTIAL : ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      prog_q  <= prog_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match;
    end
  end

`ifdef SEQDET_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          tmo_q, tmo_d;

  // The cycle that would bring the idle count to TIMEOUT_CYC fires the timeout instead.
  always_comb begin
    idle_d  = '0;
    tmo_d   = 1'b0;
    tmo_hit = 1'b0;
    if (!clear && !din_valid && (state_q == ST_PARTIAL)) begin
      if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo_hit = 1'b1;
        tmo_d   = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
